// File: rtl/d_cache_wb_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dc_state_t;

  function automatic int dc_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int dc_word_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int dc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int dc_tag_w(input int addr_w, input int data_w,
                                  input int lines, input int words);
    return addr_w - dc_idx_w(lines) - dc_word_w(words) - dc_off_w(data_w);
  endfunction

endpackage

// File: rtl/d_cache_wb_if.sv
// CPU-side and memory-side buses of the data cache; slave is the cache view.
interface d_cache_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_be;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_miss;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/d_cache_wb_array.sv
// Line storage: tag/valid/dirty per line plus data words; one read port and
// one write port sharing the line index. Only valid and dirty are reset.
module d_cache_array #(
  parameter int DATA_W = 32,
  parameter int LINES  = 256,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(LINES)-1:0]       i_idx,
  input  logic [$clog2(WORDS)-1:0]       i_rd_word,
  input  logic                           i_wr_en,
  input  logic [$clog2(WORDS)-1:0]       i_wr_word,
  input  logic [DATA_W-1:0]              i_wr_data,
  input  logic [DATA_W/8-1:0]            i_wr_be,
  input  logic                           i_meta_en,
  input  logic [TAG_W-1:0]               i_meta_tag,
  input  logic                           i_meta_valid,
  input  logic                           i_meta_dirty,
  output logic                           o_valid,
  output logic                           o_dirty,
  output logic [TAG_W-1:0]               o_tag,
  output logic [DATA_W-1:0]              o_rdata
);
  localparam int I = $clog2(LINES);
  localparam int O = $clog2(WORDS);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES*WORDS];

  logic [I+O-1:0] w_rd_ptr;
  logic [I+O-1:0] w_wr_ptr;

  assign w_rd_ptr = {i_idx, i_rd_word};
  assign w_wr_ptr = {i_idx, i_wr_word};

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_rdata = r_data[w_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_meta_en) begin
      r_valid[i_idx] <= i_meta_valid;
      r_dirty[i_idx] <= i_meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (i_meta_en) r_tag[i_idx] <= i_meta_tag;
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wr_be[b]) r_data[w_wr_ptr][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/d_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with a miss controller
// that writes back a dirty victim and refills the line word by word.
//
// state     | meaning
// IDLE      | serve hits combinationally, detect misses
// WRITEBACK | stream dirty victim words to memory
// REFILL    | fetch requested line from memory, then mark valid/clean
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 256,
  parameter int WORDS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  d_cache_wb_if.slave   bus
);
  localparam int B = dc_off_w(DATA_W);
  localparam int O = dc_word_w(WORDS);
  localparam int I = dc_idx_w(LINES);
  localparam int T = dc_tag_w(ADDR_W, DATA_W, LINES, WORDS);

  dc_state_t   r_state;
  logic [O-1:0] r_beat;
  logic [T-1:0] r_victim_tag;

  logic [T-1:0]        w_req_tag;
  logic [I-1:0]        w_idx;
  logic [O-1:0]        w_word;
  logic                w_line_valid;
  logic                w_line_dirty;
  logic [T-1:0]        w_line_tag;
  logic [DATA_W-1:0]   w_rd_data;
  logic [O-1:0]        w_rd_word;
  logic                w_hit;
  logic                w_last;
  logic                w_wr_en;
  logic [O-1:0]        w_wr_word;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W/8-1:0] w_wr_be;
  logic                w_meta_en;
  logic                w_meta_dirty;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_unused_addr_bits;

  assign w_req_tag = bus.cpu_addr[ADDR_W-1 -: T];
  assign w_idx     = bus.cpu_addr[B+O +: I];
  assign w_word    = bus.cpu_addr[B +: O];
  assign w_unused_addr_bits = &{1'b0, bus.cpu_addr[B-1:0]};

  assign w_hit     = (r_state == IDLE) && bus.cpu_req && w_line_valid &&
                     (w_line_tag == w_req_tag);
  assign w_last    = (r_beat == O'(WORDS-1));
  // Outside IDLE the read port follows the beat so write-back sees victim data.
  assign w_rd_word = (r_state == IDLE) ? w_word : r_beat;

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_word    = w_word;
    w_wr_data    = bus.cpu_wdata;
    w_wr_be      = bus.cpu_be;
    w_meta_en    = 1'b0;
    w_meta_dirty = 1'b0;
    if (w_hit && bus.cpu_we) begin
      w_wr_en      = 1'b1;
      w_meta_en    = 1'b1;
      w_meta_dirty = 1'b1;
    end else if ((r_state == REFILL) && bus.mem_ack) begin
      w_wr_en      = 1'b1;
      w_wr_word    = r_beat;
      w_wr_data    = bus.mem_rdata;
      w_wr_be      = '1;
      w_meta_en    = w_last;
      w_meta_dirty = 1'b0;
    end
  end

  d_cache_array #(
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS),
    .TAG_W  (T)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_idx        (w_idx),
    .i_rd_word    (w_rd_word),
    .i_wr_en      (w_wr_en),
    .i_wr_word    (w_wr_word),
    .i_wr_data    (w_wr_data),
    .i_wr_be      (w_wr_be),
    .i_meta_en    (w_meta_en),
    .i_meta_tag   (w_req_tag),
    .i_meta_valid (1'b1),
    .i_meta_dirty (w_meta_dirty),
    .o_valid      (w_line_valid),
    .o_dirty      (w_line_dirty),
    .o_tag        (w_line_tag),
    .o_rdata      (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_victim_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req && !w_hit) begin
            r_beat       <= '0;
            r_victim_tag <= w_line_tag;
            r_state      <= (w_line_valid && w_line_dirty) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack) begin
            r_beat <= w_last ? '0 : r_beat + O'(1);
            if (w_last) r_state <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            r_beat <= w_last ? '0 : r_beat + O'(1);
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      WRITEBACK: w_mem_addr = {r_victim_tag, w_idx, r_beat, {B{1'b0}}};
      REFILL:    w_mem_addr = {w_req_tag,    w_idx, r_beat, {B{1'b0}}};
      default:   w_mem_addr = '0;
    endcase
  end

  assign bus.cpu_ready = w_hit;
  assign bus.cpu_rdata = (w_hit && !bus.cpu_we) ? w_rd_data : '0;
  assign bus.cpu_miss  = (r_state != IDLE);
  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = (r_state == WRITEBACK);
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = (r_state == WRITEBACK) ? w_rd_data : '0;

endmodule

// File: tb/tb_d_cache_wb.sv
// Bench for d_cache_wb: architectural memory model, predicted beat queue,
// randomized ack delays and a per-cycle output monitor.
module tb_d_cache_wb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 256;
  localparam int WORDS  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_cache_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  d_cache_wb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       log_q[$];
  logic [31:0] arch_mem [logic [31:0]];
  logic [31:0] back_mem [logic [31:0]];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [19:0] m_tag   [LINES];

  int n_checks = 0;
  int n_errors = 0;
  int max_dly  = 0;
  bit spurious = 1'b0;
  int ack_count = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    if (arch_mem.exists(a)) return arch_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (back_mem.exists(a)) return back_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Memory slave: random delay per beat, checks each beat against the prediction.
  int    r_dly = 0;
  bit    r_pending = 1'b0;
  bit    r_hold = 1'b0;
  logic [31:0] r_hold_addr = '0;
  bit    r_hold_we = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    beat_t got;
    if (!rst_n) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      r_pending = 1'b0;
      r_hold    = 1'b0;
    end else begin
      if (r_hold) begin
        chk("mem_req_held", 32'(bus.mem_req), 32'd1);
        chk("mem_addr_stable", bus.mem_addr, r_hold_addr);
        chk("mem_we_stable", 32'(bus.mem_we), 32'(r_hold_we));
      end
      r_hold = 1'b0;
      if (bus.mem_req) begin
        if (!r_pending) begin
          r_pending = 1'b1;
          r_dly = int'($urandom_range(0, max_dly));
        end
        if (r_dly == 0) begin
          r_pending = 1'b0;
          got.addr = bus.mem_addr;
          got.we   = bus.mem_we;
          got.data = bus.mem_we ? bus.mem_wdata : back_rd(bus.mem_addr);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got addr %h we %0d, required no beat", got.addr, got.we);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", got.addr, e.addr);
            chk("beat_we", 32'(got.we), 32'(e.we));
            if (e.we) chk("wb_data", got.data, e.data);
          end
          if (got.we) back_mem[got.addr] = got.data;
          bus.mem_rdata = got.we ? 32'h0 : got.data;
          bus.mem_ack   = 1'b1;
          ack_count++;
          log_q.push_back(got);
        end else begin
          r_dly--;
          bus.mem_ack = 1'b0;
          r_hold      = 1'b1;
          r_hold_addr = bus.mem_addr;
          r_hold_we   = bus.mem_we;
        end
      end else begin
        r_pending     = 1'b0;
        bus.mem_ack   = spurious;
        bus.mem_rdata = spurious ? 32'hBAD0_BAD0 : 32'h0;
      end
    end
  end

  // Per-cycle output rules and request-hold protocol.
  logic [69:0] p_req_vec = '0;
  bit          p_ok = 1'b0;

  always @(negedge clk) begin
    logic [69:0] cur;
    if (!rst_n) begin
      p_ok = 1'b0;
    end else begin
      cur = {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_be};
      chk("ready_while_miss", 32'(bus.cpu_ready & bus.cpu_miss), 32'd0);
      chk("mem_req_eq_miss", 32'(bus.mem_req), 32'(bus.cpu_miss));
      if (!bus.cpu_req) chk("ready_without_req", 32'(bus.cpu_ready), 32'd0);
      if (!bus.cpu_ready || bus.cpu_we) chk("rdata_zero", bus.cpu_rdata, 32'd0);
      if (bus.cpu_miss && p_ok) chk("protocol_req_held", 32'(cur != p_req_vec), 32'd0);
      p_req_vec = cur;
      p_ok = 1'b1;
    end
  end

  task automatic predict(input logic [31:0] a, output bit hit);
    logic [7:0]  idx;
    logic [19:0] tg;
    beat_t       b;
    idx = a[11:4];
    tg  = a[31:12];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < WORDS; w++) begin
          b.addr = {m_tag[idx], idx, 2'(w), 2'b00};
          b.we   = 1'b1;
          b.data = arch_rd(b.addr);
          exp_q.push_back(b);
        end
      end
      for (int w = 0; w < WORDS; w++) begin
        b.addr = {tg, idx, 2'(w), 2'b00};
        b.we   = 1'b0;
        b.data = '0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Entered and left at posedge+1.
  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    bit          hit;
    logic [7:0]  idx;
    logic [31:0] la;
    idx = a[11:4];
    la  = {a[31:2], 2'b00};
    predict(a, hit);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    bus.cpu_be    = be;
    lat = -1;
    rd  = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL access_timeout: got no cpu_ready for addr %h, required ready within 300 cycles", a);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "access timeout");
    end
    rd = bus.cpu_rdata;
    chk("hit_iff_zero_latency", 32'(lat == 0), 32'(hit));
    chk("beats_done_at_ready", 32'(exp_q.size()), 32'd0);
    if (!we) chk("load_data", rd, arch_rd(la));
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:12];
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      arch_mem[la] = merge(arch_rd(la), wd, be);
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          base;
    bit          reached;
    bit          hit;

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req_during", 32'(bus.mem_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_miss", 32'(bus.cpu_miss), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk);
    #1;

    arch_mem[32'h1004] = 32'hCAFE_0004;
    back_mem[32'h1004] = 32'hCAFE_0004;
    arch_mem[32'h1008] = 32'h1234_5678;
    back_mem[32'h1008] = 32'h1234_5678;

    // Cold load miss.
    log_q.delete();
    access(32'h0000_1004, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("cold_latency", 32'(lat), 32'd5);
    chk("cold_beats", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cold_beat_addr", log_q[i].addr, 32'h1000 + 32'(4*i));
        chk("cold_beat_we", 32'(log_q[i].we), 32'd0);
      end
    end
    chk("cold_rdata", rd, 32'hCAFE_0004);

    // Store hit, then readback.
    log_q.delete();
    access(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 4'b0011, lat, rd);
    chk("store_hit_latency", 32'(lat), 32'd0);
    chk("store_hit_no_beats", 32'(log_q.size()), 32'd0);
    access(32'h0000_1008, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("store_merge_rdata", rd, 32'h1234_BEEF);

    // Dirty victim eviction.
    log_q.delete();
    access(32'h0000_2000, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("dirty_latency", 32'(lat), 32'd9);
    chk("dirty_beats", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk("wb_beat_addr", log_q[i].addr, 32'h1000 + 32'(4*i));
        chk("wb_beat_we", 32'(log_q[i].we), 32'd1);
        chk("rf_beat_addr", log_q[i+4].addr, 32'h2000 + 32'(4*i));
        chk("rf_beat_we", 32'(log_q[i+4].we), 32'd0);
      end
      chk("wb_merged_word", log_q[2].data, 32'h1234_BEEF);
      chk("wb_word1", log_q[1].data, 32'hCAFE_0004);
    end

    // Spurious ack in IDLE, idle and during a hit.
    log_q.delete();
    spurious = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("spurious_no_miss", 32'(bus.cpu_miss), 32'd0);
      @(posedge clk);
      #1;
    end
    access(32'h0000_2008, 1'b0, 32'h0, 4'h0, lat, rd);
    spurious = 1'b0;
    access(32'h0000_2004, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("spurious_hit_latency", 32'(lat), 32'd0);
    access(32'h0000_2008, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("spurious_line_intact", rd, arch_rd(32'h2008));
    chk("spurious_no_beats", 32'(log_q.size()), 32'd0);

    // Reset in the middle of refill beat 2.
    log_q.delete();
    base = ack_count;
    predict(32'h0000_5004, hit);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_5004;
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (ack_count >= base + 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reset_test_reached_beat2", 32'(reached), 32'd1);
    @(posedge clk);
    #2;
    chk("beat2_req_before_reset", 32'(bus.mem_req), 32'd1);
    chk("beat2_addr_before_reset", bus.mem_addr, 32'h5008);
    rst_n = 1'b0;
    #1;
    chk("reset_abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset_abort_miss", 32'(bus.cpu_miss), 32'd0);
    chk("reset_abort_ready", 32'(bus.cpu_ready), 32'd0);
    bus.cpu_req = 1'b0;
    exp_q.delete();
    arch_mem = back_mem;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_q.delete();
    access(32'h0000_5004, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("post_reset_latency", 32'(lat), 32'd5);
    chk("post_reset_refill_beats", 32'(log_q.size()), 32'd4);
    access(32'h0000_2004, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("post_reset_cache_empty", 32'(lat > 0), 32'd1);

    // Randomized traffic with 0-5 cycle ack delay over a conflict-heavy pool.
    max_dly = 5;
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic [31:0] tg;
      logic [31:0] ix;
      logic [31:0] wi;
      tg = 32'($urandom_range(0, 3));
      ix = 32'($urandom_range(0, 7));
      wi = 32'($urandom_range(0, 3));
      a  = (tg << 12) | (ix << 4) | (wi << 2);
      access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), lat, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("no_outstanding_beats", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule

// File: doc/d_cache_wb.md
# d_cache_wb

Parametrised direct-mapped, write-back, write-allocate data cache for the MEM stage of the pipeline. Lines are multi-word. Hits complete in the request cycle. Misses stall the core while a controller FSM writes back a dirty victim, then refills the line over a word-serial memory handshake. This block replaces the single-word, write-through-on-hit-only cache with one that services misses itself.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width. Must be a multiple of 8.
- `LINES`, 256: number of lines. Power of 2, ≥2.
- `WORDS`, 4: words per line. Power of 2, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  access request. Must be held with stable addr/we/wdata/be until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_W  byte address. Low log2(DATA_W/8) bits are ignored.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_be`  in  DATA_W/8  store byte enables.
- `cpu_rdata`  out  DATA_W  load data. Valid when `cpu_ready` is high and `cpu_we` is 0; 0 otherwise.
- `cpu_ready`  out  1  access completes this cycle.
- `cpu_miss`  out  1  high whenever the FSM is not IDLE (stall).
- `mem_req`  out  1  memory beat request. Held until `mem_ack`.
- `mem_we`  out  1  1 = write-back beat, 0 = refill beat.
- `mem_addr`  out  ADDR_W  word-aligned byte address of the beat.
- `mem_wdata`  out  DATA_W  write-back data.
- `mem_rdata`  in  DATA_W  refill data. Valid with `mem_ack`.
- `mem_ack`  in  1  beat complete. Ignored when `mem_req` is 0.

## Operation
- Address split:
  - byte offset B = log2(DATA_W/8)
  - word offset O = log2(WORDS)
  - index I = log2(LINES)
  - tag = the remaining `ADDR_W-I-O-B` upper bits.
- Per-line storage: valid, dirty, tag, and WORDS data words. Only valid and dirty are reset.
- FSM states: IDLE, WRITEBACK, REFILL.
  - **IDLE.** Hit = `cpu_req` && valid[idx] && tag match.
    - Load hit: `cpu_ready`=1 and `cpu_rdata`=word.
    - Store hit: `cpu_ready`=1; bytes selected by `cpu_be` are written at the edge; dirty set.
    - Miss, victim valid and dirty: go to WRITEBACK with beat counter 0 and the victim tag latched.
    - Miss otherwise: go to REFILL with beat counter 0.
  - **WRITEBACK.** `mem_req`=1, `mem_we`=1. `mem_addr` = {victim tag, idx, beat, B'0}. `mem_wdata` = victim word[beat].
    - On `mem_ack`: beat++.
    - On ack of the last beat (WORDS-1): beat←0, go to REFILL.
  - **REFILL.** `mem_req`=1, `mem_we`=0. `mem_addr` = {req tag, idx, beat, B'0}.
    - On `mem_ack`: word[beat]←`mem_rdata`, beat++.
    - On the last beat: tag←req tag, valid←1, dirty←0, go to IDLE.
- After REFILL the held request hits in IDLE on the next cycle. A store miss merges there, so it is write-allocate.
- `cpu_ready` is never high outside IDLE. A request may retire only once.
- `cpu_req` low in IDLE: no state change, `cpu_ready`=0.
- Changing the request while `cpu_miss`=1 is a protocol violation. The bench flags it; the RTL behaviour is undefined.

## Timing
- Reset values: FSM=IDLE, beat=0, all valid=0, all dirty=0. `cpu_ready`, `cpu_miss`, `mem_req`, `mem_we` are 0. `mem_addr`, `mem_wdata`, `cpu_rdata` are 0.
- Reset asserted mid-WRITEBACK or mid-REFILL: immediate abort; `mem_req` drops asynchronously; the cache is empty after reset.
- Hit latency: 0 cycles (combinational `cpu_ready`).
- Miss latency with a single-cycle ack: clean victim WORDS+1 cycles; dirty victim 2·WORDS+1 cycles. Each extra cycle of ack delay adds one cycle.
- `mem_ack` arriving in the same cycle `mem_req` first rises is legal and completes that beat.
- Beat counter wraps 0..WORDS-1. It never exceeds the last index.

## Structure
- Shared package `d_cache_pkg` holds:
  - the state enum `dc_state_t` {IDLE, WRITEBACK, REFILL}
  - localparam helpers that compute B/O/I/tag widths from the parameters.
- Natural sub-module: `d_cache_array`. It holds the tag, valid and dirty bits plus data storage. It has one read port (index, word) and one write port (byte-enabled word write, line-meta write). Valid and dirty reset asynchronously. The FSM and address muxing stay in `d_cache_wb`.

## Test plan
All scenarios use defaults: I=8, O=2, B=2, tag = addr[31:12].
- Load 0x0000_1004 after reset (cold miss).
  - Required: 4 REFILL beats at 0x1000, 0x1004, 0x1008, 0x100C with zero write-back beats.
  - Then `cpu_ready` with rdata = memory[0x1004]; total 5 cycles with single-cycle ack.
- Store 0x0000_1008, wdata 0xDEADBEEF, be 4'b0011, to a resident line.
  - Required: `cpu_ready` in the same cycle with no `mem_req`.
  - A following load returns {old[31:16], 16'hBEEF}.
- Load 0x0000_2000 with line 0 dirty from the previous scenario.
  - Required: write-back beats 0x1000–0x100C carrying the merged data, then refill beats 0x2000–0x200C, then `cpu_ready`.
- Random `mem_ack` delay of 0–5 cycles over 1000 random accesses.
  - Required: results match a reference memory model.
  - `mem_req`/`mem_addr` stay stable until ack.
  - No double `cpu_ready` per request.
- `rst_n` pulsed low in the middle of REFILL beat 2.
  - Required: `mem_req`=0 immediately.
  - The next load to the same address misses and refills all 4 beats.
- Spurious `mem_ack` in IDLE.
  - Required: no state change, no array write.
